// File: rtl/giraffe_pkg.sv
// giraffe_pkg: shared constants, FSM states and sample packing for the ADC-to-UART path
package giraffe_pkg;
    localparam logic [7:0] HEADER = 8'hA5;
    localparam int FCNT_W = 16;
    localparam int BYTE_W = 8;
    typedef enum logic [2:0] {IDLE, HDR, DATA, CHK, WAIT, DONE} state_t;
    // bit7 stays 0 so a sample byte can never alias the header
    function automatic logic [BYTE_W-1:0] pack_sample(input logic sub, input logic [BYTE_W-3:0] dout);
        return {1'b0, sub, dout};
    endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO with synchronous flush; push+pop when full both succeed
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wp, rp;
    logic do_push, do_pop;
    assign empty = wp == rp;
    assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign do_pop = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout = mem[rp[AW-1:0]];
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wp <= '0;
            rp <= '0;
        end else if (clr) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push) wp <= wp + (AW+1)'(1);
            if (do_pop) rp <= rp + (AW+1)'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wp[AW-1:0]] <= din;
    end
endmodule

// File: rtl/adc_uart_packer.sv
// adc_uart_packer: buffers ADC results and streams header/sample/checksum frames to uart_tx
module adc_uart_packer #(
    parameter int NUM_bit = 6,
    parameter int UART_NUM_DATA = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int FRAME_LEN = 64,
    parameter logic [7:0] HEADER = giraffe_pkg::HEADER
) (
    input  logic                            clk,
    input  logic                            nrst,
    input  logic                            start,
    input  logic                            adc_ack,
    input  logic                            adc_ack_sub,
    input  logic [NUM_bit-1:0]              adc_dout,
    output logic [UART_NUM_DATA-1:0]        uart_wdata,
    output logic                            uart_wreq,
    input  logic                            uart_rdy,
    output logic                            busy,
    output logic                            overflow,
    output logic [giraffe_pkg::FCNT_W-1:0]  frame_cnt
);
    import giraffe_pkg::*;
    localparam logic [FCNT_W-1:0] LAST = FCNT_W'(FRAME_LEN);
    state_t st, st_n, ret, ret_n;
    logic [2:0] ack_s;
    logic cap_v;
    logic [UART_NUM_DATA-1:0] cap_b, fifo_q, wdata_n, chk, chk_n;
    logic [FCNT_W-1:0] cnt, cnt_n, fcnt_n;
    logic [1:0] wt, wt_n;
    logic seen, seen_n, wreq_n, busy_n, ovf_n, pop, clr, push, full, empty;

    assign push = cap_v && busy;

    sync_fifo #(.WIDTH(UART_NUM_DATA), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .nrst(nrst), .clr(clr), .push(push), .pop(pop),
        .din(cap_b), .dout(fifo_q), .full(full), .empty(empty)
    );

    // two sync flops, edge detect, then a capture register: FIFO write lands 3 cycles after adc_ack
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ack_s <= '0;
            cap_v <= 1'b0;
            cap_b <= '0;
        end else begin
            ack_s <= {ack_s[1:0], adc_ack};
            cap_v <= ack_s[1] && !ack_s[2];
            cap_b <= UART_NUM_DATA'(pack_sample(adc_ack_sub, (BYTE_W-2)'(adc_dout)));
        end
    end

    always_comb begin
        st_n = st;
        ret_n = ret;
        wdata_n = uart_wdata;
        wreq_n = 1'b0;
        chk_n = chk;
        cnt_n = cnt;
        wt_n = '0;
        seen_n = 1'b0;
        busy_n = busy;
        fcnt_n = frame_cnt;
        pop = 1'b0;
        clr = 1'b0;
        case (st)
            IDLE: if (start) begin
                st_n = HDR;
                clr = 1'b1;
                chk_n = '0;
                cnt_n = '0;
                busy_n = 1'b1;
            end
            HDR: if (uart_rdy) begin
                wdata_n = UART_NUM_DATA'(HEADER);
                wreq_n = 1'b1;
                ret_n = DATA;
                st_n = WAIT;
            end
            DATA: if (!empty && uart_rdy) begin
                pop = 1'b1;
                wdata_n = fifo_q;
                wreq_n = 1'b1;
                chk_n = chk ^ fifo_q;
                cnt_n = cnt + FCNT_W'(1);
                ret_n = (cnt_n == LAST) ? CHK : DATA;
                st_n = WAIT;
            end
            CHK: if (uart_rdy) begin
                wdata_n = chk;
                wreq_n = 1'b1;
                ret_n = DONE;
                st_n = WAIT;
            end
            // a uart_tx that never drops rdy is assumed to have taken the byte after 4 cycles
            WAIT: if (seen ? uart_rdy : (uart_rdy && wt == 2'd3)) st_n = ret;
                  else begin
                      seen_n = seen || !uart_rdy;
                      wt_n = wt + 2'd1;
                  end
            DONE: begin
                fcnt_n = frame_cnt + FCNT_W'(1);
                busy_n = 1'b0;
                st_n = IDLE;
            end
            default: st_n = IDLE;
        endcase
        ovf_n = (st == IDLE && start) ? 1'b0 : overflow || (push && full && !pop);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            st <= IDLE;
            ret <= IDLE;
            uart_wdata <= '0;
            uart_wreq <= 1'b0;
            chk <= '0;
            cnt <= '0;
            wt <= '0;
            seen <= 1'b0;
            busy <= 1'b0;
            overflow <= 1'b0;
            frame_cnt <= '0;
        end else begin
            st <= st_n;
            ret <= ret_n;
            uart_wdata <= wdata_n;
            uart_wreq <= wreq_n;
            chk <= chk_n;
            cnt <= cnt_n;
            wt <= wt_n;
            seen <= seen_n;
            busy <= busy_n;
            overflow <= ovf_n;
            frame_cnt <= fcnt_n;
        end
    end
endmodule

// File: tb/tb_adc_uart_packer.sv
// tb_adc_uart_packer: randomized frames checked against a byte-stream model of the packer
module tb_adc_uart_packer;
    localparam int FL = 4, DEPTH = 16;
    logic clk = 0, nrst = 0, start = 0, adc_ack = 0, adc_ack_sub = 0, tx_idle = 1, hold_rdy = 0;
    logic [5:0] adc_dout = 0;
    logic [7:0] uart_wdata;
    logic uart_wreq, uart_rdy, busy, overflow;
    logic [15:0] frame_cnt;
    int errors = 0, checks = 0;
    logic [7:0] exp_q[$], log_q[$];
    logic m_busy = 0, m_ovf = 0, prev_wreq = 0;
    logic [15:0] m_fcnt = 0;
    logic [7:0] m_chk = 0;
    int m_n = 0, m_cap = 0;

    assign uart_rdy = tx_idle && !hold_rdy;
    always #5 clk = ~clk;

    adc_uart_packer #(.FRAME_LEN(FL), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .nrst(nrst), .start(start), .adc_ack(adc_ack), .adc_ack_sub(adc_ack_sub),
        .adc_dout(adc_dout), .uart_wdata(uart_wdata), .uart_wreq(uart_wreq), .uart_rdy(uart_rdy),
        .busy(busy), .overflow(overflow), .frame_cnt(frame_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // every emitted byte is checked against the expected stream and the handshake rules
    initial forever begin
        @(negedge clk);
        if (nrst && uart_wreq) begin
            check("wreq_while_not_rdy", uart_rdy, 1);
            check("wreq_back_to_back", prev_wreq, 0);
            log_q.push_back(uart_wdata);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_byte: got %h, expected none", uart_wdata);
            end else check("byte", uart_wdata, exp_q.pop_front());
        end
        prev_wreq = nrst && uart_wreq;
    end

    // uart_tx stand-in: busy for 10 cycles after each accepted write
    initial forever begin
        @(negedge clk);
        if (uart_wreq && uart_rdy) begin
            @(posedge clk);
            #1 tx_idle = 0;
            repeat (10) @(posedge clk);
            #1 tx_idle = 1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1;
        tick();
        start = 0;
        if (!m_busy) begin
            m_busy = 1; m_ovf = 0; m_n = 0; m_cap = 0; m_chk = 0;
            exp_q.push_back(8'hA5);
        end
    endtask

    task automatic send_ack(input logic sub, input logic [5:0] d);
        logic [7:0] b = {1'b0, sub, d};
        adc_ack_sub = sub; adc_dout = d; adc_ack = 1;
        if (m_busy) begin
            if (hold_rdy && m_cap >= DEPTH) m_ovf = 1;
            else begin
                m_cap++;
                if (m_n < FL) begin
                    exp_q.push_back(b);
                    m_chk ^= b;
                    m_n++;
                    if (m_n == FL) exp_q.push_back(m_chk);
                end
            end
        end
        tick(4);
        adc_ack = 0;
        tick(3);
    endtask

    task automatic wait_done(input string name);
        int t = 0;
        while ((busy || exp_q.size() != 0) && t < 3000) begin
            tick();
            t++;
        end
        checks++;
        if (t >= 3000) begin
            errors++;
            $display("FAIL %s_timeout: busy=%b pending=%0d, required idle with none pending", name, busy, exp_q.size());
        end
        m_busy = 0;
        m_fcnt++;
        exp_q.delete();
        check({name, "_busy"}, busy, 0);
        check({name, "_frame_cnt"}, frame_cnt, m_fcnt);
        check({name, "_overflow"}, overflow, m_ovf);
    endtask

    task automatic do_reset();
        #2 nrst = 0;
        #1;
        check("rst_wdata", uart_wdata, 0);
        check("rst_wreq", uart_wreq, 0);
        check("rst_busy", busy, 0);
        check("rst_overflow", overflow, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        exp_q.delete();
        m_busy = 0; m_ovf = 0; m_fcnt = 0;
        tick(2);
        @(negedge clk);
        nrst = 1;
        tick();
    endtask

    initial begin
        logic [7:0] basic[6] = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
        tick(2);
        do_reset();

        log_q.delete();
        for (int i = 0; i < 3; i++) send_ack(0, 6'(i + 9));
        tick(20);
        check("idle_no_bytes", log_q.size(), 0);

        log_q.delete();
        do_start();
        for (int i = 1; i <= 4; i++) send_ack(0, 6'(i));
        wait_done("basic");
        check("basic_len", log_q.size(), 6);
        for (int i = 0; i < 6; i++) check("basic_lit", (i < log_q.size()) ? log_q[i] : 8'hxx, basic[i]);

        log_q.delete();
        do_start();
        send_ack(1, 6'h3F);
        for (int i = 1; i <= 3; i++) send_ack(0, 6'(i));
        wait_done("sub");
        check("sub_byte", (log_q.size() > 1) ? log_q[1] : 8'hxx, 8'h7F);
        check("sub_chk", (log_q.size() > 5) ? log_q[5] : 8'hxx, 8'h7F);

        do_start();
        send_ack(0, 6'h11);
        send_ack(1, 6'h22);
        do_start();
        send_ack(0, 6'h33);
        send_ack(1, 6'h05);
        wait_done("busy_start");

        for (int f = 0; f < 6; f++) begin
            do_start();
            tick($urandom_range(0, 5));
            for (int i = 0; i < FL + $urandom_range(0, 2); i++) begin
                send_ack(1'($urandom), 6'($urandom));
                if ($urandom_range(0, 3) == 0) do_start();
            end
            wait_done("rand");
        end

        hold_rdy = 1;
        do_start();
        for (int i = 0; i < DEPTH; i++) send_ack(1'($urandom), 6'($urandom));
        tick(4);
        check("ovf_at_depth", overflow, 0);
        send_ack(0, 6'h2A);
        tick(4);
        check("ovf_set", overflow, 1);
        hold_rdy = 0;
        wait_done("ovf");
        do_start();
        tick(2);
        check("ovf_cleared", overflow, 0);
        for (int i = 0; i < FL; i++) send_ack(1'($urandom), 6'($urandom));
        wait_done("after_ovf");

        do_start();
        for (int i = 0; i < FL; i++) send_ack(0, 6'(i + 20));
        for (int t = 0; t < 500 && exp_q.size() > 3; t++) tick();
        check("midframe_progress", exp_q.size() <= 3, 1);
        do_reset();
        log_q.delete();
        do_start();
        for (int i = 0; i < FL; i++) send_ack(1'($urandom), 6'($urandom));
        wait_done("post_reset");
        check("post_reset_hdr", (log_q.size() > 0) ? log_q[0] : 8'hxx, 8'hA5);

        force dut.frame_cnt = 16'hFFFF;
        tick();
        release dut.frame_cnt;
        m_fcnt = 16'hFFFF;
        tick();
        check("wrap_pre", frame_cnt, 16'hFFFF);
        do_start();
        for (int i = 0; i < FL; i++) send_ack(1'($urandom), 6'($urandom));
        wait_done("wrap");
        check("wrap_zero", frame_cnt, 0);

        tick(5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
